ooo_front_exec: RTL and testbench
=================================

// Module: ooo_front_exec
// PURPOSE
//  Single-issue ISA core for the OOO pipeline: instruction ROM (fetch), combinational decoder, and
//  combinational per-entry execute datapath. Fetch stage drives pc and consumes decoded fields.
//  ROB instantiates the execute half (ex_* ports) once per entry; it is pure logic, independent of clk.
// PARAMETERS
//  INST_LEN       8   instruction width: [7:6] op, [5:4] rd, [3:2] rs1/imm, [1:0] rs2
//  MEMI_SIZE_LOG  4   log2 of ROM depth (16 words); also pc width
//  REG_LEN        4   data register width
//  RF_SIZE_LOG    2   register index width
//  MEMD_SIZE_LOG  2   data-memory address width
//  INST_SIZE_LOG  2   opcode width
// PORTS
//  clk                 in   1              clock (single clock domain)
//  rst                 in   1              asynchronous, active-high reset
//  pc                  in   MEMI_SIZE_LOG  fetch address
//  inst                out  INST_LEN       ROM[pc], combinational
//  opcode              out  INST_SIZE_LOG  inst[7:6]
//  rs1_used/rs2_used   out  1              source operand read enables
//  rs1/rs2/rd          out  RF_SIZE_LOG    inst[3:2] / inst[1:0] / inst[5:4], always driven
//  rs1_imm             out  REG_LEN        zero-extended inst[3:2]
//  rs1_br_offset       out  MEMI_SIZE_LOG  sign-extended inst[5:2]
//  wen, rd_data_use_alu, mem_valid, is_br  out 1  decode control flags
//  ex_pc, ex_op, ex_rs1_imm, ex_rs1_br_offset, ex_rs1_data, ex_rs2_data  in  execute operands
//  ex_rd_data_use_alu, ex_is_br  in 1 ; ex_mem_data in REG_LEN (memd[ex_mem_addr])
//  ex_mem_addr  out MEMD_SIZE_LOG ; ex_rd_data out REG_LEN ; ex_taken out 1 ; ex_next_pc out MEMI_SIZE_LOG
// BEHAVIOUR
//  ROM: rst (async) loads the image; otherwise contents hold forever (no write port). Read is combinational.
//  Opcodes (flags: wen/rs1_used/rs2_used/use_alu/mem_valid/is_br):
//   0 LI  rd=imm               1/0/0/1/0/0
//   1 ADD rd=rs1+rs2           1/1/1/1/0/0  sum mod 2^REG_LEN, carry dropped
//   2 LD  rd=memd[rs1]         1/1/0/0/1/0  ex_mem_addr = ex_rs1_data[MEMD_SIZE_LOG-1:0]
//   3 BR  if rs2==0 pc+=off    0/0/1/1/0/1
//  Execute: alu = imm (LI), rs1+rs2 (ADD), 0 otherwise; ex_rd_data = use_alu ? alu : ex_mem_data.
//  ex_mem_addr = 0 unless op==LD. ex_taken = ex_is_br && ex_rs2_data==0.
//  ex_next_pc = ex_taken ? ex_pc+ex_rs1_br_offset : ex_pc+1, both wrap mod 2^MEMI_SIZE_LOG.
//  Zero latency on all outputs. No output registers, so no output has a reset value of its own;
//  during and after reset, inst reflects the reloaded image immediately.
//  Reset asserted mid-run reloads the ROM asynchronously; decode follows combinationally.
// CONFIGURATION
//  MEMI_INIT_PROG_EN defined: reset loads the demo program
//   0:0x18 LI r1,2 | 1:0x24 LI r2,1 | 2:0x76 ADD r3,r1,r2 | 3:0x84 LD r0,[r1] | 4:0xF0 BR r0==0,-4
//   remaining words 0x00.
//  Undefined: every word resets to 0x00 (LI r0,0).
// STRUCTURE
//  Shared package/header: width constants above; opcode codes OP_LI=0, OP_ADD=1, OP_LD=2, OP_BR=3.
//  One sub-module: inst_rom (clk, rst, addr -> data, reset image).
//  Decode and execute are always blocks in the top.
// TESTING
//  Macro on, pulse rst, pc=2 -> inst=0x76, opcode=1, rd=3, rs1=1, rs2=2, wen=1, rs1_used=rs2_used=1.
//  pc=4 -> is_br=1, wen=0, rs1_br_offset=4'hC.
//   Then ex_pc=4, ex_is_br=1, ex_rs2_data=0 -> taken=1, next_pc=0.
//   Same with ex_rs2_data=3 -> taken=0, next_pc=5.
//  ADD with rs1=4'hF, rs2=4'h2 -> ex_rd_data=4'h1 (wrap); ex_mem_addr=0, taken=0.
//  LD with ex_rs1_data=4'h6, ex_mem_data=4'h9, use_alu=0 -> ex_mem_addr=2'b10, ex_rd_data=9.
//  ex_pc=15, non-branch -> next_pc=0.
//  Macro off: after rst, pc=3 -> inst=0x00.
//  rst asserted without clk edge -> ROM image present immediately.

Source files
------------

// File: rtl/ooo_front_exec_pkg.sv
// Shared widths and opcode encoding for the single-issue front end / execute core.
package ooo_front_exec_pkg;

    localparam int INST_LEN      = 8;
    localparam int MEMI_SIZE_LOG = 4;
    localparam int REG_LEN       = 4;
    localparam int RF_SIZE_LOG   = 2;
    localparam int MEMD_SIZE_LOG = 2;
    localparam int INST_SIZE_LOG = 2;
    localparam int ROM_DEPTH     = 1 << MEMI_SIZE_LOG;

    typedef enum logic [INST_SIZE_LOG-1:0] {
        OP_LI  = 2'd0,
        OP_ADD = 2'd1,
        OP_LD  = 2'd2,
        OP_BR  = 2'd3
    } op_e;

endpackage

// File: rtl/ooo_front_exec_inst_rom.sv
// Instruction ROM: reset (async) loads the image, contents then hold; combinational read.
// MEMI_INIT_PROG_EN selects the demo program image; otherwise every word resets to 0x00.
module inst_rom
    import ooo_front_exec_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [MEMI_SIZE_LOG-1:0] addr,
    output logic [INST_LEN-1:0]      data
);

    logic [INST_LEN-1:0] mem_q [ROM_DEPTH];
    logic [INST_LEN-1:0] mem_d [ROM_DEPTH];

    function automatic logic [INST_LEN-1:0] reset_word(input logic [MEMI_SIZE_LOG-1:0] idx);
        logic [INST_LEN-1:0] w;
        w = '0;
`ifdef MEMI_INIT_PROG_EN
        case (idx)
            4'd0:    w = 8'h18;
            4'd1:    w = 8'h24;
            4'd2:    w = 8'h76;
            4'd3:    w = 8'h84;
            4'd4:    w = 8'hF0;
            default: w = 8'h00;
        endcase
`else
        w = idx == idx ? 8'h00 : 8'h00;
`endif
        return w;
    endfunction

    // No write port: the next-state of every word is its current value.
    always_comb begin
        for (int i = 0; i < ROM_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ROM_DEPTH; i++) begin
                mem_q[i] <= reset_word(i[MEMI_SIZE_LOG-1:0]);
            end
        end else begin
            for (int i = 0; i < ROM_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign data = mem_q[addr];

endmodule

// File: rtl/ooo_front_exec.sv
// Single-issue core slice: instruction ROM, combinational decoder and combinational execute datapath.
// Build option MEMI_INIT_PROG_EN (in inst_rom) selects the demo program as the reset image.
module ooo_front_exec
    import ooo_front_exec_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [MEMI_SIZE_LOG-1:0] pc,
    output logic [INST_LEN-1:0]      inst,
    output logic [INST_SIZE_LOG-1:0] opcode,
    output logic                     rs1_used,
    output logic                     rs2_used,
    output logic [RF_SIZE_LOG-1:0]   rs1,
    output logic [RF_SIZE_LOG-1:0]   rs2,
    output logic [RF_SIZE_LOG-1:0]   rd,
    output logic [REG_LEN-1:0]       rs1_imm,
    output logic [MEMI_SIZE_LOG-1:0] rs1_br_offset,
    output logic                     wen,
    output logic                     rd_data_use_alu,
    output logic                     mem_valid,
    output logic                     is_br,
    input  logic [MEMI_SIZE_LOG-1:0] ex_pc,
    input  logic [INST_SIZE_LOG-1:0] ex_op,
    input  logic [REG_LEN-1:0]       ex_rs1_imm,
    input  logic [MEMI_SIZE_LOG-1:0] ex_rs1_br_offset,
    input  logic [REG_LEN-1:0]       ex_rs1_data,
    input  logic [REG_LEN-1:0]       ex_rs2_data,
    input  logic                     ex_rd_data_use_alu,
    input  logic                     ex_is_br,
    input  logic [REG_LEN-1:0]       ex_mem_data,
    output logic [MEMD_SIZE_LOG-1:0] ex_mem_addr,
    output logic [REG_LEN-1:0]       ex_rd_data,
    output logic                     ex_taken,
    output logic [MEMI_SIZE_LOG-1:0] ex_next_pc
);

    logic [REG_LEN-1:0] alu_res;

    inst_rom u_inst_rom (
        .clk  (clk),
        .rst  (rst),
        .addr (pc),
        .data (inst)
    );

    // Field extraction is unconditional; only the control flags depend on the opcode.
    always_comb begin
        opcode          = inst[7:6];
        rd              = inst[5:4];
        rs1             = inst[3:2];
        rs2             = inst[1:0];
        rs1_imm         = {{(REG_LEN-RF_SIZE_LOG){1'b0}}, inst[3:2]};
        rs1_br_offset   = inst[5:2];
        wen             = 1'b0;
        rs1_used        = 1'b0;
        rs2_used        = 1'b0;
        rd_data_use_alu = 1'b0;
        mem_valid       = 1'b0;
        is_br           = 1'b0;
        case (op_e'(inst[7:6]))
            OP_LI: begin
                wen             = 1'b1;
                rd_data_use_alu = 1'b1;
            end
            OP_ADD: begin
                wen             = 1'b1;
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
                rd_data_use_alu = 1'b1;
            end
            OP_LD: begin
                wen             = 1'b1;
                rs1_used        = 1'b1;
                mem_valid       = 1'b1;
            end
            OP_BR: begin
                rs2_used        = 1'b1;
                rd_data_use_alu = 1'b1;
                is_br           = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op_e'(ex_op))
            OP_LI:   alu_res = ex_rs1_imm;
            OP_ADD:  alu_res = ex_rs1_data + ex_rs2_data;
            default: alu_res = '0;
        endcase
    end

    // Taken only looks at the branch flag, not the opcode, so the ROB entry decides.
    always_comb begin
        ex_rd_data  = ex_rd_data_use_alu ? alu_res : ex_mem_data;
        ex_mem_addr = (op_e'(ex_op) == OP_LD) ? ex_rs1_data[MEMD_SIZE_LOG-1:0] : '0;
        ex_taken    = ex_is_br && (ex_rs2_data == '0);
        ex_next_pc  = ex_taken ? ex_pc + ex_rs1_br_offset : ex_pc + 1'b1;
    end

endmodule

// File: tb/tb_ooo_front_exec.sv
// Scoreboard bench for ooo_front_exec: directed spec cases plus randomized decode/execute traffic.
module tb_ooo_front_exec;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] pc = '0;
    logic [7:0] inst;
    logic [1:0] opcode, rs1, rs2, rd;
    logic       rs1_used, rs2_used, wen, rd_data_use_alu, mem_valid, is_br;
    logic [3:0] rs1_imm, rs1_br_offset;
    logic [3:0] ex_pc = '0;
    logic [1:0] ex_op = '0;
    logic [3:0] ex_rs1_imm = '0, ex_rs1_br_offset = '0, ex_rs1_data = '0, ex_rs2_data = '0;
    logic       ex_rd_data_use_alu = 1'b0, ex_is_br = 1'b0;
    logic [3:0] ex_mem_data = '0;
    logic [1:0] ex_mem_addr;
    logic [3:0] ex_rd_data;
    logic       ex_taken;
    logic [3:0] ex_next_pc;

    localparam int W = 41;
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    ooo_front_exec dut (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst), .opcode(opcode),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rs1(rs1), .rs2(rs2), .rd(rd),
        .rs1_imm(rs1_imm), .rs1_br_offset(rs1_br_offset), .wen(wen),
        .rd_data_use_alu(rd_data_use_alu), .mem_valid(mem_valid), .is_br(is_br),
        .ex_pc(ex_pc), .ex_op(ex_op), .ex_rs1_imm(ex_rs1_imm),
        .ex_rs1_br_offset(ex_rs1_br_offset), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_rd_data_use_alu(ex_rd_data_use_alu),
        .ex_is_br(ex_is_br), .ex_mem_data(ex_mem_data), .ex_mem_addr(ex_mem_addr),
        .ex_rd_data(ex_rd_data), .ex_taken(ex_taken), .ex_next_pc(ex_next_pc)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] img(input int a);
`ifdef MEMI_INIT_PROG_EN
        case (a)
            0: return 8'h18;
            1: return 8'h24;
            2: return 8'h76;
            3: return 8'h84;
            4: return 8'hF0;
            default: return 8'h00;
        endcase
`else
        return (a >= 0) ? 8'h00 : 8'h00;
`endif
    endfunction

    // {inst, opcode, rs1_used, rs2_used, rs1, rs2, rd, rs1_imm, br_off, wen, use_alu, mem_valid, is_br}
    function automatic logic [29:0] model_dec(input int a);
        logic [7:0] w;
        int         op;
        logic [5:0] f;  // wen, rs1_used, rs2_used, use_alu, mem_valid, is_br
        w  = img(a);
        op = int'(w) / 64;
        case (op)
            0: f = 6'b100100;
            1: f = 6'b111100;
            2: f = 6'b110010;
            default: f = 6'b001101;
        endcase
        return {w, 2'(op), f[4], f[3], 2'((int'(w) / 4) % 4), 2'(int'(w) % 4),
                2'((int'(w) / 16) % 4), 4'((int'(w) / 4) % 4), 4'((int'(w) / 4) % 16),
                f[5], f[2], f[1], f[0]};
    endfunction

    // {mem_addr, rd_data, taken, next_pc}
    function automatic logic [10:0] model_ex(input int epc, input int op, input int imm,
                                             input int off, input int r1, input int r2,
                                             input bit use_alu, input bit br, input int md);
        int alu, rdv, addr, nxt;
        bit tk;
        alu  = (op == 0) ? imm : (op == 1) ? (r1 + r2) % 16 : 0;
        rdv  = use_alu ? alu : md;
        addr = (op == 2) ? r1 % 4 : 0;
        tk   = br && (r2 == 0);
        nxt  = tk ? (epc + off) % 16 : (epc + 1) % 16;
        return {2'(addr), 4'(rdv), tk, 4'(nxt)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply(input string nm, input int a, input int epc, input int op,
                         input int imm, input int off, input int r1, input int r2,
                         input bit use_alu, input bit br, input int md);
        @(posedge clk);
        #1;
        pc = 4'(a); ex_pc = 4'(epc); ex_op = 2'(op); ex_rs1_imm = 4'(imm);
        ex_rs1_br_offset = 4'(off); ex_rs1_data = 4'(r1); ex_rs2_data = 4'(r2);
        ex_rd_data_use_alu = use_alu; ex_is_br = br; ex_mem_data = 4'(md);
        exp_q.push_back({model_dec(a), model_ex(epc, op, imm, off, r1, r2, use_alu, br, md)});
        name_q.push_back(nm);
    endtask

    task automatic rand_one(input string nm);
        apply(nm, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] act, exp;
        string        nm;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {inst, opcode, rs1_used, rs2_used, rs1, rs2, rd, rs1_imm, rs1_br_offset,
                   wen, rd_data_use_alu, mem_valid, is_br,
                   ex_mem_addr, ex_rd_data, ex_taken, ex_next_pc};
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", nm, act, exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int wait_cyc;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        // ROM image is visible while reset is still held
        apply("reset_img_pc0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        apply("reset_img_pc4", 4, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(posedge clk);
        #2 rst = 1'b0;

        apply("dec_pc2_add", 2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        apply("dec_pc3", 3, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        apply("br_taken", 4, 4, 3, 0, 12, 0, 0, 1, 1, 0);
        apply("br_not_taken", 4, 4, 3, 0, 12, 0, 3, 1, 1, 0);
        apply("add_wrap", 2, 7, 1, 0, 0, 15, 2, 1, 0, 0);
        apply("ld_mem", 3, 7, 2, 0, 0, 6, 5, 0, 0, 9);
        apply("pc_wrap", 0, 15, 0, 3, 0, 0, 0, 1, 0, 0);
        apply("li_imm", 1, 3, 0, 2, 0, 9, 9, 1, 0, 5);
        apply("br_wrap_fwd", 4, 14, 3, 0, 3, 0, 0, 1, 1, 0);

        for (int i = 0; i < 40; i++) rand_one("rand_a");

        // Async reset mid-cycle: no clock edge between assertion and the check
        @(posedge clk);
        #2 rst = 1'b1;
        pc = 4'd1;
        exp_q.push_back({model_dec(1), model_ex(0, 0, 0, 0, 0, 0, 1, 0, 0)});
        name_q.push_back("async_rst_img");
        ex_pc = '0; ex_op = '0; ex_rs1_imm = '0; ex_rs1_br_offset = '0; ex_rs1_data = '0;
        ex_rs2_data = '0; ex_rd_data_use_alu = 1'b1; ex_is_br = 1'b0; ex_mem_data = '0;
        @(negedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 40; i++) rand_one("rand_b");

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
